decoder_grant_scheduler: RTL and testbench

- Round-robin scheduler that shares one 2-to-4 decoder select path among four requesters.
- Emits a registered 2-bit select, suitable for driving the 2-to-4 decoder's `in` port, plus a registered one-hot grant and valid flag.
- Bounds occupancy with a hold limit so no requester can starve the others.
- Sits between requesting agents and the decoder datapath.

---
 rtl/decoder_grant_scheduler.sv | 84 ++++++++
 tb/tb_decoder_grant_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_grant_scheduler.sv
// Round-robin scheduler sharing one 2-to-4 decoder select path among four requesters.
// Registered one-hot grant/select/valid outputs; a hold limit bounds occupancy while others wait.
module decoder_grant_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   gnt_sel,
    output logic               gnt_valid,
    output logic [HOLD_W-1:0]  hold_cnt
);

    // state | meaning
    // IDLE  | no grant outstanding; next edge with a request picks a winner
    // BUSY  | gnt_sel holds the decoder; released on request drop or hold-limit preemption
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [SEL_W-1:0]   last_winner;
    logic [SEL_W-1:0]   winner;
    logic               found;
    logic [NUM_REQ-1:0] others;
    logic               release_now;

    // Rotating scan starting just past the previous winner; the previous winner is checked last.
    always_comb begin
        winner = last_winner;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[last_winner + SEL_W'(i)]) begin
                winner = last_winner + SEL_W'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        others      = req & ~gnt;
        release_now = !req[gnt_sel] ||
                      ((hold_cnt == HOLD_W'(MAX_HOLD)) && (|others));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_sel     <= '0;
            gnt_valid   <= 1'b0;
            hold_cnt    <= '0;
            last_winner <= SEL_W'(NUM_REQ - 1);
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= NUM_REQ'(1) << winner;
                        gnt_sel   <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HOLD_W'(1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        gnt         <= '0;
                        gnt_valid   <= 1'b0;
                        last_winner <= gnt_sel;
                        hold_cnt    <= '0;
                        state       <= IDLE;
                    end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_grant_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized phase,
// every cycle compared against an integer-level round-robin model.
module tb_decoder_grant_scheduler;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_sel;
    logic       gnt_valid;
    logic [3:0] hold_cnt;

    int checks   = 0;
    int failures = 0;

    // model: holder index, busy flag, consecutive-grant count, previous winner
    int m_busy = 0;
    int m_sel  = 0;
    int m_cnt  = 0;
    int m_last = 3;

    decoder_grant_scheduler dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt), .gnt_sel(gnt_sel), .gnt_valid(gnt_valid), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_sel = 0; m_cnt = 0; m_last = 3;
        end else if (en) begin
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        int c;
                        c = (m_last + k) % 4;
                        if (!m_busy && req[c]) begin
                            m_busy = 1; m_sel = c; m_cnt = 1;
                        end
                    end
                end
            end else begin
                int others;
                others = int'(req) & ~(1 << m_sel);
                if (!req[m_sel] || (m_cnt == MAX_HOLD && others != 0)) begin
                    m_busy = 0; m_last = m_sel; m_cnt = 0;
                end else if (m_cnt < MAX_HOLD) begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_gnt", int'(gnt), m_busy ? (1 << m_sel) : 0);
            chk("model_sel", int'(gnt_sel), m_sel);
            chk("model_valid", int'(gnt_valid), m_busy);
            chk("model_hold", int'(hold_cnt), m_cnt);
            chk("inv_onehot", int'(gnt), gnt_valid ? (1 << gnt_sel) : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // 1: round robin from reset with every holder dropping after one cycle
        req = 4'b1111;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_grant", int'(gnt), 1 << i);
            req[i] = 1'b0;
            tick();
            chk("t1_gap", int'(gnt), 0);
        end
        tick();

        // 2: hold-limit preemption between two constant requesters
        req = 4'b0011;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= MAX_HOLD; k++) begin
                tick();
                chk("t2_gnt", int'(gnt), 1 << r);
                chk("t2_hold", int'(hold_cnt), k);
            end
            tick();
            chk("t2_gap", int'(gnt), 0);
        end
        tick();
        chk("t2_back", int'(gnt), 1);
        req = 4'b0000;
        tick(); tick();

        // 3: sole requester keeps the grant, counter saturates
        req = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t3_gnt", int'(gnt), 4);
            chk("t3_sel", int'(gnt_sel), 2);
            chk("t3_hold", int'(hold_cnt), (k < MAX_HOLD) ? k : MAX_HOLD);
        end
        req = 4'b0000;
        tick(); tick();

        // 4: enable freeze at hold_cnt=3
        req = 4'b0010;
        tick(); tick(); tick();
        chk("t4_pre_hold", int'(hold_cnt), 3);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req = 4'($urandom_range(0, 15));
            tick();
            chk("t4_gnt", int'(gnt), 2);
            chk("t4_sel", int'(gnt_sel), 1);
            chk("t4_hold", int'(hold_cnt), 3);
        end
        req = 4'b0010;
        en  = 1'b1;
        tick();
        chk("t4_resume", int'(hold_cnt), 4);
        req = 4'b0000;
        tick(); tick();

        // 5: asynchronous reset mid-grant
        req = 4'b1000;
        tick();
        chk("t5_gnt", int'(gnt), 8);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_gnt", int'(gnt), 0);
        chk("t5_async_valid", int'(gnt_valid), 0);
        req = 4'b1001;
        tick();
        rst = 1'b0;
        tick();
        chk("t5_after", int'(gnt), 1);
        req = 4'b0000;
        tick(); tick();

        // 6: early release then handover
        req = 4'b0110;
        tick();
        chk("t6_gnt", int'(gnt), 2);
        tick();
        chk("t6_hold", int'(hold_cnt), 2);
        req = 4'b0100;
        tick();
        chk("t6_gap", int'(gnt), 0);
        tick();
        chk("t6_next", int'(gnt), 4);

        // randomized traffic, occasional freezes and async resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
